// File: rtl/lo_gen_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | lo_gen_pkg : shared modes, phase indices and segment helpers       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package lo_gen_pkg;

  typedef enum logic [1:0] {
    LO_OFF  = 2'd0,
    LO_EXT  = 2'd1,
    LO_DIFF = 2'd2,
    LO_QUAD = 2'd3
  } lo_mode_e;

  localparam int PH_IP = 0;
  localparam int PH_QP = 1;
  localparam int PH_IN = 2;
  localparam int PH_QN = 3;

  localparam int SEGS_DIFF = 2;
  localparam int SEGS_QUAD = 4;

  function automatic logic [1:0] last_seg(input lo_mode_e m);
    logic [1:0] r;
    r = 2'd0;
    case (m)
      LO_DIFF: r = 2'(SEGS_DIFF - 1);
      LO_QUAD: r = 2'(SEGS_QUAD - 1);
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  // One-hot phase drive owned by segment seg in the given internal mode.
  function automatic logic [3:0] seg_onehot(input lo_mode_e m, input logic [1:0] seg);
    logic [3:0] oh;
    oh = 4'b0000;
    case (m)
      LO_DIFF: begin
        if (seg[0]) oh[PH_IN] = 1'b1;
        else        oh[PH_IP] = 1'b1;
      end
      LO_QUAD: begin
        case (seg)
          2'd0:    oh[PH_IP] = 1'b1;
          2'd1:    oh[PH_QP] = 1'b1;
          2'd2:    oh[PH_IN] = 1'b1;
          default: oh[PH_QN] = 1'b1;
        endcase
      end
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage : lo_gen_pkg
`default_nettype wire

// File: rtl/lo_sync2.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | lo_sync2 : two-flop synchroniser, async active-high reset to 0     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module lo_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule : lo_sync2
`default_nettype wire

// File: rtl/lo_phase_generator.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | lo_phase_generator : shadowed-config LO generator, diff/quad/ext   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module lo_phase_generator
  import lo_gen_pkg::*;
#(
  parameter int DIV_W  = 8,
  parameter int DEAD_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        cfg_mode,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DEAD_W-1:0] cfg_dead,
  input  logic              cfg_load,
  input  logic              ext_lo_p,
  input  logic              ext_lo_n,
  output logic [3:0]        phase,
  output logic              period_start,
  output logic              cfg_pending
);

  localparam int CMP_W = (DIV_W > DEAD_W) ? DIV_W : DEAD_W;

  lo_mode_e          mode_q, sh_mode_q;
  logic [DIV_W-1:0]  div_q, sh_div_q;
  logic [DEAD_W-1:0] dead_q, sh_dead_q;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        seg_q, seg_d;
  logic              pend_q;
  logic [3:0]        phase_q, phase_d;
  logic              pstart_q, pstart_d;
  logic              ext_ip_q;

  logic w_sp, w_sn;
  logic w_internal, w_seg_end, w_period_end, w_apply, w_active;
  logic w_ext_ip, w_ext_in;

  lo_sync2 u_sync_p (.clk(clk), .rst(rst), .async_i(ext_lo_p), .sync_o(w_sp));
  lo_sync2 u_sync_n (.clk(clk), .rst(rst), .async_i(ext_lo_n), .sync_o(w_sn));

  assign w_internal   = (mode_q == LO_DIFF) || (mode_q == LO_QUAD);
  assign w_seg_end    = (cnt_q == div_q);
  assign w_period_end = w_internal && w_seg_end && (seg_q == last_seg(mode_q));
  // Internal modes only switch on a period boundary so no pulse is ever cut short.
  assign w_apply      = pend_q && (!w_internal || w_period_end);
  assign w_active     = CMP_W'(cnt_q) >= CMP_W'(dead_q);
  assign w_ext_ip     = w_sp & ~w_sn;
  assign w_ext_in     = w_sn & ~w_sp;

  always_comb begin
    cnt_d = cnt_q;
    seg_d = seg_q;
    if (!w_internal) begin
      cnt_d = '0;
      seg_d = 2'd0;
    end else if (w_seg_end) begin
      cnt_d = '0;
      seg_d = (seg_q == last_seg(mode_q)) ? 2'd0 : seg_q + 2'd1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    phase_d  = 4'b0000;
    pstart_d = 1'b0;
    case (mode_q)
      LO_EXT: begin
        phase_d[PH_IP] = w_ext_ip;
        phase_d[PH_IN] = w_ext_in;
        pstart_d       = w_ext_ip & ~ext_ip_q;
      end
      LO_DIFF, LO_QUAD: begin
        phase_d  = w_active ? seg_onehot(mode_q, seg_q) : 4'b0000;
        pstart_d = (cnt_q == '0) && (seg_q == 2'd0);
      end
      default: begin
        phase_d  = 4'b0000;
        pstart_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= LO_OFF;
      div_q     <= '0;
      dead_q    <= '0;
      sh_mode_q <= LO_OFF;
      sh_div_q  <= '0;
      sh_dead_q <= '0;
      cnt_q     <= '0;
      seg_q     <= 2'd0;
      pend_q    <= 1'b0;
      phase_q   <= 4'b0000;
      pstart_q  <= 1'b0;
      ext_ip_q  <= 1'b0;
    end else begin
      if (cfg_load) begin
        sh_mode_q <= lo_mode_e'(cfg_mode);
        sh_div_q  <= cfg_div;
        sh_dead_q <= cfg_dead;
      end
      if (w_apply) begin
        mode_q <= sh_mode_q;
        div_q  <= sh_div_q;
        dead_q <= sh_dead_q;
        cnt_q  <= '0;
        seg_q  <= 2'd0;
      end else begin
        cnt_q <= cnt_d;
        seg_q <= seg_d;
      end
      pend_q   <= cfg_load | (pend_q & ~w_apply);
      phase_q  <= phase_d;
      pstart_q <= pstart_d;
      ext_ip_q <= w_ext_ip;
    end
  end

  assign phase        = phase_q;
  assign period_start = pstart_q;
  assign cfg_pending  = pend_q;

endmodule : lo_phase_generator
`default_nettype wire

// File: tb/tb_lo_phase_generator.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_lo_phase_generator : directed self-checking bench               |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_lo_phase_generator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] cfg_mode = 2'd0;
  logic [7:0] cfg_div = 8'd0;
  logic [2:0] cfg_dead = 3'd0;
  logic       cfg_load = 1'b0;
  logic       ext_lo_p = 1'b0;
  logic       ext_lo_n = 1'b0;
  logic [3:0] phase;
  logic       period_start;
  logic       cfg_pending;

  int n_checks = 0;
  int n_fail   = 0;

  // Hand-derived sequences, one entry per cycle starting at the first decoded state.
  logic [3:0] exp_diff [8]  = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h4, 4'h4, 4'h4};
  logic [3:0] exp_quad [16] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2,
                                4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h8};
  logic [3:0] exp_q2 [8]    = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8};
  logic       ext_p [14]    = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0};
  logic       ext_n [14]    = '{0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1};
  logic [3:0] exp_ext [14]  = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h4, 4'h4,
                                4'h4, 4'h0, 4'h1, 4'h1, 4'h1, 4'h4, 4'h4};
  logic       exp_eps [14]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};

  lo_phase_generator #(.DIV_W(8), .DEAD_W(3)) dut (
    .clk(clk), .rst(rst),
    .cfg_mode(cfg_mode), .cfg_div(cfg_div), .cfg_dead(cfg_dead), .cfg_load(cfg_load),
    .ext_lo_p(ext_lo_p), .ext_lo_n(ext_lo_n),
    .phase(phase), .period_start(period_start), .cfg_pending(cfg_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called at a negedge while the active mode is off or external (immediate apply).
  task automatic load_cfg(input logic [1:0] m, input logic [7:0] d, input logic [2:0] dd);
    cfg_mode = m; cfg_div = d; cfg_dead = dd; cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
    check("pend_set", 32'(cfg_pending), 32'd1);
    @(negedge clk);
    check("pend_clr", 32'(cfg_pending), 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_phase", 32'(phase), 32'h0);
    check("rst_pstart", 32'(period_start), 32'd0);
    check("rst_pend", 32'(cfg_pending), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_phase", 32'(phase), 32'h0);

    // Differential, L=4, dead=1
    load_cfg(2'd2, 8'd3, 3'd1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("diff_ph", 32'(phase), 32'(exp_diff[i % 8]));
      check("diff_ps", 32'(period_start), (i % 8 == 0) ? 32'd1 : 32'd0);
    end

    // Quadrature, L=4, dead=1, then a mid-period reload to L=2
    pulse_reset();
    load_cfg(2'd3, 8'd3, 3'd1);
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      check("quad_ph", 32'(phase), 32'(exp_quad[i % 16]));
      check("quad_ps", 32'(period_start), (i % 16 == 0) ? 32'd1 : 32'd0);
      check("quad_1hot", ($countones(phase) <= 1) ? 32'd1 : 32'd0, 32'd1);
      if (i >= 32)
        check("quad_pend", 32'(cfg_pending), (i >= 37 && i <= 46) ? 32'd1 : 32'd0);
      if (i == 36) begin
        cfg_mode = 2'd3; cfg_div = 8'd1; cfg_dead = 3'd1; cfg_load = 1'b1;
      end
      if (i == 37) cfg_load = 1'b0;
    end
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      check("q2_ph", 32'(phase), 32'(exp_q2[j % 8]));
      check("q2_ps", 32'(period_start), (j % 8 == 0) ? 32'd1 : 32'd0);
      check("q2_pend", 32'(cfg_pending), 32'd0);
    end

    // Asynchronous reset while phase[0] is high
    rst = 1'b1;
    #1;
    check("arst_phase", 32'(phase), 32'h0);
    check("arst_pend", 32'(cfg_pending), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("post_rst_ph", 32'(phase), 32'h0);
      check("post_rst_ps", 32'(period_start), 32'd0);
    end

    // dead >= L: phases silent, period_start keeps its cadence
    load_cfg(2'd2, 8'd3, 3'd4);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("dead_ph", 32'(phase), 32'h0);
      check("dead_ps", 32'(period_start), (i % 8 == 0) ? 32'd1 : 32'd0);
    end

    // External pass-through with a two-cycle overlap
    pulse_reset();
    load_cfg(2'd1, 8'd0, 3'd0);
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      if (k >= 3) begin
        check("ext_ph", 32'(phase), 32'(exp_ext[k - 3]));
        check("ext_ps", 32'(period_start), 32'(exp_eps[k - 3]));
      end
      ext_lo_p = (k < 14) ? ext_p[k] : 1'b0;
      ext_lo_n = (k < 14) ? ext_n[k] : 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_lo_phase_generator
`default_nettype wire

// File: doc/lo_phase_generator.md
# lo_phase_generator

Parametrised local-oscillator generator driving the Gilbert-cell switching quad; successor to the single-pair mixer control. Produces either a differential LO or a four-phase 25 % duty quadrature LO from an internal programmable divider, or passes through a synchronised external LO. Every mode enforces break-before-make dead time. Configuration changes are shadowed and applied only at a period boundary so the mixer never sees a runt pulse.

## Interface
- DIV_W, 8: width of half-segment divider value
- DEAD_W, 3: width of dead-time value
- clk  in  1  clock
- rst  in  1  reset; one clock, reset is asynchronous and active-high
- cfg_mode  in  2  0 = off, 1 = external pass-through, 2 = internal differential, 3 = internal quadrature
- cfg_div  in  DIV_W  segment length minus one (L = cfg_div + 1 cycles)
- cfg_dead  in  DEAD_W  dead cycles at the start of each segment
- cfg_load  in  1  strobe; captures cfg_* into the shadow register
- ext_lo_p, ext_lo_n  in  1 each  asynchronous external LO pair
- phase  out  4  LO drives: [0] I+, [1] Q+, [2] I−, [3] Q−
- period_start  out  1  one-cycle pulse on the first cycle of segment 0
- cfg_pending  out  1  shadow loaded but not yet applied

## Operation
- Registers: active config (mode, div, dead), shadow config, segment counter cnt (DIV_W), segment index seg (2 bits), pending flag.
- cfg_load: shadow <= cfg_*, pending <= 1. A load while pending overwrites the shadow (last one wins).
- Apply: when pending and (active mode is off or external, or the cycle is the last cycle of the last segment): active <= shadow, cnt <= 0, seg <= 0, pending <= 0. A cfg_load on the apply cycle itself is captured into the shadow and stays pending.
- Off: phase = 0, counters held at 0, no period_start.
- Internal: cnt counts 0..L−1; on wrap, seg advances. Differential uses seg 0,1 (wrap after 1); quadrature uses seg 0..3.
  - Differential: seg 0 drives phase[0], seg 1 drives phase[2]; phase[1], phase[3] = 0.
  - Quadrature: seg k drives phase[k].
  - Driven phase is high only for cnt >= dead; if dead >= L the outputs stay low while counters run.
- External: ext_lo_p/n each go through a two-flop synchroniser; phase[0] = sp & ~sn, phase[2] = sn & ~sp; both high or both low -> both low; phase[1], phase[3] = 0; period_start pulses on each rising edge of the synchronised phase[0] term.
- At most one phase bit is ever high (invariant, every mode).

## Timing
- Reset: phase = 0, period_start = 0, cfg_pending = 0, active and shadow mode = off, div = 0, dead = 0, cnt = 0, seg = 0.
- All outputs registered: outputs at cycle t reflect cnt/seg/mode at t−1.
- From off: cfg_load at cycle t -> pending high at t+1, applied at t+1 (pending low at t+2), cnt = 0 at t+2, period_start and first phase decision visible at t+3.
- Internal period: 2·L cycles differential, 4·L quadrature; high time per phase L − dead.
- External latency ext pin -> phase: 3 cycles (2 sync + output reg).
- Reset asserted mid-period: outputs go 0 asynchronously, no partial pulse after deassertion; config returns to off.

## Structure
- Package lo_gen_pkg: mode enum (LO_OFF, LO_EXT, LO_DIFF, LO_QUAD), phase index constants (PH_IP, PH_QP, PH_IN, PH_QN), segment count per mode.
- Sub-module lo_sync2: two-flop synchroniser with async active-high reset to 0, instantiated per external input.
- Top: config/shadow logic, counter/segment FSM, output decode register.

## Test plan
- Reset then cfg_mode=2, div=3, dead=1, load -> period 8; phase[0] high 3 cycles, 1 low, phase[2] high 3, 1 low; period_start every 8 cycles.
- cfg_mode=3, div=3, dead=1 -> period 16; phase[0..3] each high 3 cycles in order, never two high at once.
- Mid-period in mode 3, load div=1 -> cfg_pending high until last cycle of seg 3; next period is 8 cycles, no truncated pulse.
- dead=4, div=3 in mode 2 -> phase stays 0, period_start still every 8 cycles.
- Mode 1, ext_lo_p/ext_lo_n toggled complementary, with a 2-cycle overlap where both are high -> phase[0]/phase[2] follow with 3-cycle latency; overlap produces both low.
- Assert rst mid-quadrature -> phase = 0 immediately; after release, outputs stay 0 until a new cfg_load.
